// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial multicycle ALU, one 1-bit slice, LSB first
// Captures operands on Start, shifts WIDTH bits through the slice, then resolves MSB flags.
module alu_serial_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUop,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Carry_out,
   output logic             Overflow
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [3:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic             cin_msb_q, cin_msb_d;
   logic             set_bit_q, set_bit_d;
   logic             cout_msb_q, cout_msb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic bit_a, bit_b, bit_sum, bit_carry, bit_res;
   logic ovf_calc, less, last_bit;

   always_comb begin
      bit_a     = a_sh_q[0] ^ op_q[3];
      bit_b     = b_sh_q[0] ^ op_q[2];
      bit_sum   = bit_a ^ bit_b ^ carry_q;
      bit_carry = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
      case (op_q[1:0])
         2'b00:   bit_res = bit_a & bit_b;
         2'b01:   bit_res = bit_a | bit_b;
         2'b10:   bit_res = bit_sum;
         default: bit_res = 1'b0;
      endcase
      ovf_calc = cin_msb_q ^ cout_msb_q;
      // Less corrected by overflow so SLT stays signed-correct across the wrap
      less     = set_bit_q ^ ovf_calc;
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));

      state_d    = state_q;
      cnt_d      = cnt_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      op_d       = op_q;
      carry_d    = carry_q;
      res_sh_d   = res_sh_q;
      cin_msb_d  = cin_msb_q;
      set_bit_d  = set_bit_q;
      cout_msb_d = cout_msb_q;
      result_d   = result_q;
      zero_d     = zero_q;
      cout_d     = cout_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               a_sh_d  = A;
               b_sh_d  = B;
               op_d    = ALUop;
               carry_d = ALUop[2];
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = bit_carry;
            res_sh_d = {bit_res, res_sh_q[WIDTH-1:1]};
            if (last_bit) begin
               cin_msb_d  = carry_q;
               set_bit_d  = bit_sum;
               cout_msb_d = bit_carry;
               state_d    = S_FINISH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FINISH: begin
            ovf_d  = ovf_calc;
            cout_d = cout_msb_q;
            if (op_q[1:0] == 2'b11) begin
               result_d = {{(WIDTH-1){1'b0}}, less};
            end else begin
               result_d = res_sh_q;
            end
            zero_d  = (result_d == '0);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         op_q       <= '0;
         carry_q    <= 1'b0;
         res_sh_q   <= '0;
         cin_msb_q  <= 1'b0;
         set_bit_q  <= 1'b0;
         cout_msb_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         op_q       <= op_d;
         carry_q    <= carry_d;
         res_sh_q   <= res_sh_d;
         cin_msb_q  <= cin_msb_d;
         set_bit_q  <= set_bit_d;
         cout_msb_q <= cout_msb_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Result    = result_q;
   assign Zero      = zero_q;
   assign Carry_out = cout_q;
   assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed self-checking bench for alu_serial_seq
module tb_alu_serial_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       Start;
   logic [7:0] A, B;
   logic [3:0] ALUop;
   logic       Busy, Done, Zero, Carry_out, Overflow;
   logic [7:0] Result;

   int checks = 0;
   int errors = 0;
   int lat, bcnt;

   alu_serial_seq #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .ALUop(ALUop),
      .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero),
      .Carry_out(Carry_out), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // caller sits 1 time unit after a rising edge; returns just after the accepting edge
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      Start = 1'b1;
      A     = a;
      B     = b;
      ALUop = op;
      step();
      Start = 1'b0;
   endtask

   task automatic wait_done(output int cycles, output int busy_cycles);
      cycles      = 0;
      busy_cycles = Busy ? 1 : 0;
      while (!Done && cycles < 50) begin
         step();
         cycles++;
         if (Busy) busy_cycles++;
      end
   endtask

   initial begin
      rst = 1'b1; Start = 1'b0; A = '0; B = '0; ALUop = '0;
      step(); step();
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_result", 32'(Result), 32'd0);
      check("rst_zero", 32'(Zero), 32'd0);
      check("rst_cout", 32'(Carry_out), 32'd0);
      check("rst_ovf", 32'(Overflow), 32'd0);
      rst = 1'b0;
      step();

      // ADD 7F+01
      start_op(8'h7F, 8'h01, 4'b0010);
      A = 8'hAA; B = 8'h55;
      wait_done(lat, bcnt);
      check("add_latency", 32'(lat), 32'd9);
      check("add_busy_cycles", 32'(bcnt), 32'd9);
      check("add_result", 32'(Result), 32'h80);
      check("add_ovf", 32'(Overflow), 32'd1);
      check("add_cout", 32'(Carry_out), 32'd0);
      check("add_zero", 32'(Zero), 32'd0);
      step();
      check("done_pulse_width", 32'(Done), 32'd0);
      check("result_held", 32'(Result), 32'h80);

      // SUB 05-05
      start_op(8'h05, 8'h05, 4'b0110);
      wait_done(lat, bcnt);
      check("sub_result", 32'(Result), 32'h00);
      check("sub_zero", 32'(Zero), 32'd1);
      check("sub_cout", 32'(Carry_out), 32'd1);
      check("sub_ovf", 32'(Overflow), 32'd0);
      step();

      // SLT -3 < 2
      start_op(8'hFD, 8'h02, 4'b0111);
      wait_done(lat, bcnt);
      check("slt_result", 32'(Result), 32'h01);
      check("slt_ovf", 32'(Overflow), 32'd0);
      step();

      // SLT -128 < 127 with overflow
      start_op(8'h80, 8'h7F, 4'b0111);
      wait_done(lat, bcnt);
      check("slt_ovf_result", 32'(Result), 32'h01);
      check("slt_ovf_flag", 32'(Overflow), 32'd1);
      check("slt_ovf_zero", 32'(Zero), 32'd0);
      step();

      // NOR
      start_op(8'h0F, 8'h33, 4'b1100);
      wait_done(lat, bcnt);
      check("nor_result", 32'(Result), 32'hC0);
      step();

      // OR with ignored mid-operation Start, then Start held in Done cycle
      start_op(8'h0F, 8'h33, 4'b0001);
      step(); step();
      start_op(8'hFF, 8'hFF, 4'b0010);
      wait_done(lat, bcnt);
      check("or_result", 32'(Result), 32'h3F);
      check("or_latency", 32'(lat), 32'd6);
      start_op(8'h10, 8'h20, 4'b0010);
      check("b2b_busy", 32'(Busy), 32'd1);
      check("b2b_done_cleared", 32'(Done), 32'd0);
      wait_done(lat, bcnt);
      check("b2b_result", 32'(Result), 32'h30);
      check("b2b_latency", 32'(lat), 32'd9);
      step();

      // reset at SHIFT bit 4
      start_op(8'h55, 8'h0F, 4'b0010);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_result", 32'(Result), 32'd0);
      check("abort_zero", 32'(Zero), 32'd0);
      check("abort_cout", 32'(Carry_out), 32'd0);
      check("abort_ovf", 32'(Overflow), 32'd0);
      repeat (12) step();
      check("abort_stays_idle", 32'({Busy, Done}), 32'd0);

      start_op(8'h01, 8'h01, 4'b0010);
      wait_done(lat, bcnt);
      check("post_rst_latency", 32'(lat), 32'd9);
      check("post_rst_result", 32'(Result), 32'h02);
      check("post_rst_flags", 32'({Zero, Carry_out, Overflow}), 32'd0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Multicycle bit-serial ALU for the calculator datapath.
- Accepts two WIDTH-bit operands and a 4-bit ALU control word on a Start handshake.
- Processes one bit per clock, LSB first, through a single 1-bit slice (invert muxes, AND, OR, full adder).
- Applies MSB handling on the last bit (Set, Overflow, Less) and returns Result and flags with a one-cycle Done pulse.
- Serves as the sequential, area-reduced counterpart to the parallel ripple ALU, driven by the calculator controller.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A, captured when Start is accepted.
- B  input  WIDTH  operand B, captured when Start is accepted.
- ALUop  input  4  control word: [3]=Ainvert, [2]=Binvert, [1:0]=Operation (00 AND, 01 OR, 10 SUM, 11 SLT); captured with the operands.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; Result and flags are valid from this cycle.
- Result  output  WIDTH  operation result, held until the next Done.
- Zero  output  1  Result == 0.
- Carry_out  output  1  carry out of the MSB adder.
- Overflow  output  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.

Behaviour:
- Single clock; reset is synchronous and active-high (rst).
- Reset values: Busy=0, Done=0, Result=0, Zero=0, Carry_out=0, Overflow=0; state=IDLE; counter=0; internal carry=0.
- Reset asserted mid-operation aborts on that edge with the same values. The partial result is discarded.
- IDLE:
  - Start=1 latches A, B, ALUop into shift/holding registers.
  - Sets carry=ALUop[2] (Binvert), counter=0, Busy=1; goes to SHIFT.
  - Start=0 holds state. Done is cleared every cycle it is not being set.
- SHIFT (one bit per edge, bit i = counter):
  - a = A[i] XOR Ainvert; b = B[i] XOR Binvert.
  - sum = a^b^carry; carry <= majority(a, b, carry).
  - Per-bit result: Operation 00 → a&b; 01 → a|b; 10 → sum; 11 → 0 (bit 0 is patched in FINISH).
  - Per-bit result is shifted into the result register MSB-first, so the register is LSB-aligned after WIDTH shifts.
  - At i = WIDTH-1, also record carry_in_msb = carry (before update), set_bit = sum, and final carry out.
  - After bit WIDTH-1, go to FINISH.
- FINISH (one edge):
  - Overflow <= carry_in_msb XOR carry_out_msb.
  - Carry_out <= carry_out_msb.
  - Less = set_bit XOR overflow. This gives signed-correct SLT under overflow.
  - If Operation=11, Result <= {0…0, Less}; otherwise Result <= shift register.
  - Zero computed from the final Result value.
  - Busy <= 0, Done <= 1; return to IDLE.
- Flags are driven from the adder path for all operations. They are meaningful only for Operation 10/11.
- Latency: Start sampled at edge N → Done high in the cycle after edge N+WIDTH+1. Busy is high for exactly WIDTH+1 cycles.
- Start while Busy=1 is ignored; no queueing. Start high in the Done cycle is accepted (state is IDLE).
- Operand inputs may change freely after acceptance; only latched copies are used.
- Counter terminal value is WIDTH-1; no wrap beyond it.
- Common encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - Other codes behave as their bit fields dictate.

Test Plan:
- ADD: A=8'h7F, B=8'h01, ALUop=0010, Start at edge 0 → Busy high 9 cycles; Done at cycle 9; Result=8'h80, Overflow=1, Carry_out=0, Zero=0.
- SUB: A=8'h05, B=8'h05, ALUop=0110 → Result=8'h00, Zero=1, Carry_out=1, Overflow=0.
- SLT without overflow: A=8'hFD (-3), B=8'h02, ALUop=0111 → Result=8'h01, Overflow=0.
- SLT with overflow: A=8'h80, B=8'h7F, ALUop=0111 → Result=8'h01, Overflow=1.
- NOR: A=8'h0F, B=8'h33, ALUop=1100 → Result=8'hC0.
- OR back-to-back: A=8'h0F, B=8'h33, ALUop=0001 → Result=8'h3F. Start is re-pulsed with new operands during Busy, which must be ignored. Start held high in the Done cycle must start a new operation.
- Reset mid-operation: rst asserted at SHIFT bit 4 → next cycle all outputs 0, state IDLE. A subsequent ADD 8'h01+8'h01 gives Result=8'h02 at normal latency.
